// File: rtl/sliding_window_frame_ctrl.sv
// Frame sequencer around a sliding_window block: admits one frame of
// pixels per start, forwards the matching number of windows, gates handshakes.
module sliding_window_frame_ctrl #(
  parameter int IMG_WIDTH      = 4,
  parameter int IMG_HEIGHT     = 3,
  parameter int KERNEL_WIDTH   = 3,
  parameter int KERNEL_HEIGHT  = 2,
  parameter int PADDING_WIDTH  = 0,
  parameter int PADDING_HEIGHT = 0,
  parameter int CHANNELS       = 2,
  parameter int STRIDE         = 1,
  localparam int PW = IMG_WIDTH + 2 * PADDING_WIDTH,
  localparam int PH = IMG_HEIGHT + 2 * PADDING_HEIGHT,
  localparam int OUT_W = (PW - KERNEL_WIDTH) / STRIDE + 1,
  localparam int OUT_H = (PH - KERNEL_HEIGHT) / STRIDE + 1,
  localparam int IN_BEATS = IMG_WIDTH * IMG_HEIGHT * CHANNELS,
  localparam int OUT_BEATS = OUT_W * OUT_H * CHANNELS,
  localparam int MAXB = (IN_BEATS > OUT_BEATS) ? IN_BEATS : OUT_BEATS,
  localparam int CW = $clog2(MAXB + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] in_count,
  output logic [CW-1:0] out_count,
  input  logic          src_valid,
  output logic          src_ready,
  output logic          win_in_valid,
  input  logic          win_in_ready,
  input  logic          win_out_valid,
  output logic          win_out_ready,
  output logic          snk_valid,
  input  logic          snk_ready
);

  localparam logic [CW-1:0] IN_MAX   = CW'(IN_BEATS);
  localparam logic [CW-1:0] IN_LAST  = CW'(IN_BEATS - 1);
  localparam logic [CW-1:0] OUT_MAX  = CW'(OUT_BEATS);
  localparam logic [CW-1:0] OUT_LAST = CW'(OUT_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t        r_state;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic [CW-1:0] r_in_count;
  logic [CW-1:0] r_out_count;

  logic w_in_open;
  logic w_out_open;
  logic w_in_hs;
  logic w_out_hs;
  logic w_in_last;
  logic w_out_last;
  logic w_out_full;

  assign w_in_open  = (r_state == RUN) && (r_in_count < IN_MAX);
  assign w_out_open = ((r_state == RUN) || (r_state == DRAIN))
                      && (r_out_count < OUT_MAX);

  assign win_in_valid  = src_valid & w_in_open;
  assign src_ready     = win_in_ready & w_in_open;
  assign snk_valid     = win_out_valid & w_out_open;
  assign win_out_ready = snk_ready & w_out_open;

  assign w_in_hs    = src_valid & src_ready;
  assign w_out_hs   = snk_valid & snk_ready;
  assign w_in_last  = w_in_hs && (r_in_count == IN_LAST);
  assign w_out_last = w_out_hs && (r_out_count == OUT_LAST);
  assign w_out_full = (r_out_count == OUT_MAX);

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign in_count  = r_in_count;
  assign out_count = r_out_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_in_count  <= '0;
      r_out_count <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_in_hs) r_in_count <= r_in_count + 1'b1;
      if (w_out_hs) r_out_count <= r_out_count + 1'b1;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state     <= RUN;
            r_busy      <= 1'b1;
            r_err       <= 1'b0;
            r_in_count  <= '0;
            r_out_count <= '0;
          end else if (win_out_valid) begin
            r_err <= 1'b1;
          end
        end
        RUN: begin
          if (win_out_valid && w_out_full) r_err <= 1'b1;
          if (w_out_last && !w_in_last) r_err <= 1'b1;
          // outputs already complete: finish rather than stall in DRAIN
          if (w_in_last) begin
            if (w_out_last || w_out_full) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (win_out_valid && w_out_full) r_err <= 1'b1;
          if (w_out_last) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          if (win_out_valid) r_err <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sliding_window_frame_ctrl.sv
// Scoreboard bench for sliding_window_frame_ctrl: a window-block model
// feeds two DUT configurations; a monitor checks every forwarded window.
module tb_sliding_window_frame_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic src_valid = 1'b0;
  logic win_in_ready = 1'b0;
  logic snk_ready = 1'b0;
  logic force_wov = 1'b0;
  logic model_clr = 1'b0;
  bit   sel = 1'b0;

  logic       busy0, done0, err0, srdy0, wiv0, wor0, skv0;
  logic       busy1, done1, err1, srdy1, wiv1, wor1, skv1;
  logic [4:0] inc0, outc0, inc1, outc1;
  logic       start0, start1, wov0, wov1, mv;

  logic       busy, done, err, src_ready, win_in_valid;
  logic       win_out_ready, snk_valid, win_out_valid;
  logic [4:0] in_count, out_count;

  int in_acc = 0;
  int k_prod = 0;
  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];
  int done_q[$];

  always #5 clk = ~clk;

  assign start0 = start & ~sel;
  assign start1 = start & sel;
  assign wov0 = mv & ~sel;
  assign wov1 = mv & sel;

  sliding_window_frame_ctrl u_dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .busy(busy0), .done(done0), .err(err0),
    .in_count(inc0), .out_count(outc0),
    .src_valid(src_valid), .src_ready(srdy0),
    .win_in_valid(wiv0), .win_in_ready(win_in_ready),
    .win_out_valid(wov0), .win_out_ready(wor0),
    .snk_valid(skv0), .snk_ready(snk_ready)
  );

  sliding_window_frame_ctrl #(
    .PADDING_WIDTH(1), .PADDING_HEIGHT(1), .STRIDE(2)
  ) u_dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .busy(busy1), .done(done1), .err(err1),
    .in_count(inc1), .out_count(outc1),
    .src_valid(src_valid), .src_ready(srdy1),
    .win_in_valid(wiv1), .win_in_ready(win_in_ready),
    .win_out_valid(wov1), .win_out_ready(wor1),
    .snk_valid(skv1), .snk_ready(snk_ready)
  );

  assign busy          = sel ? busy1 : busy0;
  assign done          = sel ? done1 : done0;
  assign err           = sel ? err1 : err0;
  assign in_count      = sel ? inc1 : inc0;
  assign out_count     = sel ? outc1 : outc0;
  assign src_ready     = sel ? srdy1 : srdy0;
  assign win_in_valid  = sel ? wiv1 : wiv0;
  assign win_out_ready = sel ? wor1 : wor0;
  assign snk_valid     = sel ? skv1 : skv0;
  assign win_out_valid = sel ? wov1 : wov0;

  // input beat index a window needs before it can be emitted
  function automatic int need(input bit s, input int k);
    int pd, st, c, ox, oy, r, col;
    pd  = s ? 1 : 0;
    st  = s ? 2 : 1;
    c   = k % 2;
    ox  = (k / 2) % 2;
    oy  = k / 4;
    r   = oy * st + 2 - 1 - pd;
    col = ox * st + 3 - 1 - pd;
    if (r < 0) r = 0;
    if (r > 2) r = 2;
    if (col < 0) col = 0;
    if (col > 3) col = 3;
    return (r * 4 + col) * 2 + c;
  endfunction

  always_comb begin
    mv = force_wov;
    if (k_prod < 8 && need(sel, k_prod) < in_acc) mv = 1'b1;
  end

  always @(posedge clk) begin
    if (rst || model_clr) begin
      in_acc <= 0;
      k_prod <= 0;
    end else begin
      if (src_valid && src_ready) in_acc <= in_acc + 1;
      if (mv && win_out_ready) k_prod <= k_prod + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (snk_valid && snk_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_window", 1, 0);
      end else begin
        chk("window_order", out_count, exp_q.pop_front());
      end
    end
    if (done) begin
      if (done_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        void'(done_q.pop_front());
        chk("done_in_count", in_count, 24);
        chk("done_out_count", out_count, 8);
      end
    end
    if (busy) begin
      chk("gate_rules", {src_ready & ~win_in_ready,
                         win_in_valid & ~src_valid,
                         snk_valid & ~win_out_valid,
                         win_out_ready & ~snk_ready,
                         (in_count == 5'd24) & (src_ready | win_in_valid)},
          0);
    end
  end

  task automatic run_frame(input int mode, input bit hold,
                           input int abort_at);
    int cyc;
    bit fin;
    for (int i = 0; i < 8; i++) exp_q.push_back(i);
    if (abort_at < 0) done_q.push_back(1);
    model_clr = 1'b1;
    @(posedge clk); #1;
    model_clr = 1'b0;
    start = 1'b1;
    src_valid = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_err", err, 0);
    chk("start_in_count", in_count, 0);
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < 400) begin
      win_in_ready = 1'b1;
      snk_ready = 1'b1;
      src_valid = 1'b1;
      if (mode == 1) begin
        snk_ready = cyc[0];
        win_in_ready = ~cyc[1];
      end else if (mode == 2) begin
        src_valid = ~cyc[0];
        snk_ready = ~cyc[2];
      end
      if (abort_at >= 0 && in_count == 5'(abort_at)) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_counts", {in_count, out_count}, 0);
        chk("abort_done", done, 0);
        exp_q.delete();
        fin = 1'b1;
      end else begin
        @(posedge clk); #1;
        cyc++;
        if (done) fin = 1'b1;
      end
    end
    if (!fin) chk("frame_timeout", cyc, 0);
    if (abort_at < 0) begin
      chk("end_counts", {in_count, out_count}, {5'd24, 5'd8});
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_done", busy, 0);
      chk("done_one_cycle", done, 0);
    end
    src_valid = 1'b0;
    snk_ready = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);
    chk("idle_err", err, 0);
    chk("queues_empty", exp_q.size() + done_q.size(), 0);
  endtask

  initial begin
    src_valid = 1'b1;
    win_in_ready = 1'b1;
    snk_ready = 1'b1;
    force_wov = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_status", {busy, done, err}, 0);
    chk("rst_counts", {in_count, out_count}, 0);
    chk("rst_gates", {src_ready, win_in_valid,
                      win_out_ready, snk_valid}, 0);
    force_wov = 1'b0;
    src_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    run_frame(0, 1'b0, -1);
    run_frame(1, 1'b0, -1);
    run_frame(2, 1'b0, -1);
    run_frame(0, 1'b1, -1);
    run_frame(0, 1'b0, 10);
    run_frame(0, 1'b0, -1);

    sel = 1'b1;
    run_frame(0, 1'b0, -1);
    run_frame(1, 1'b0, -1);
    sel = 1'b0;

    force_wov = 1'b1;
    @(negedge clk);
    chk("idle_wov_snk_valid", snk_valid, 0);
    @(posedge clk); #1;
    force_wov = 1'b0;
    chk("idle_wov_err", err, 1);
    @(posedge clk); #1;
    chk("err_sticky", err, 1);
    run_frame(0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
